// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
//   - op_e      : operation codes presented on i_op by ID/EX
//   - state_e   : iteration FSM states
//   - DIVZERO_LO: LO value written by a divide whose divisor is zero
//   - helpers   : classify an op code as iterative and/or signed
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // Wide enough for any supported BITS_SIZE; the top slices what it needs.
  localparam logic [63:0] DIVZERO_LO = '1;

  // True for ops that start a multicycle iteration.
  function automatic logic op_is_iter(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // True for ops whose operands are two's-complement.
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One radix-2 iteration of the multiply/divide datapath (purely combinational).
//   is_div : 0 = shift-add multiply step, 1 = restoring shift-subtract step
//   i_hi   : multiply accumulator / partial remainder
//   i_lo   : remaining multiplier bits / dividend-then-quotient bits
//   i_b    : multiplicand or divisor magnitude
//   o_hi, o_lo : values of i_hi/i_lo after this step
module muldiv_iter_core #(
  parameter int BITS_SIZE = 32
) (
  input  logic                 is_div,
  input  logic [BITS_SIZE-1:0] i_hi,
  input  logic [BITS_SIZE-1:0] i_lo,
  input  logic [BITS_SIZE-1:0] i_b,
  output logic [BITS_SIZE-1:0] o_hi,
  output logic [BITS_SIZE-1:0] o_lo
);

  logic [BITS_SIZE:0]   sum;
  logic [BITS_SIZE:0]   shifted;
  logic [BITS_SIZE-1:0] diff;

  always_comb begin
    // Multiply: add multiplicand when the current LSB is set, then shift the
    // {acc, multiplier} pair right by one, keeping the carry.
    sum     = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : '0);
    // Divide: bring the next dividend bit into the partial remainder.
    shifted = {i_hi, i_lo[BITS_SIZE-1]};
    // Only used when shifted >= i_b, so the result always fits BITS_SIZE.
    diff    = shifted[BITS_SIZE-1:0] - i_b;

    if (is_div) begin
      if (shifted >= {1'b0, i_b}) begin
        o_hi = diff;
        o_lo = {i_lo[BITS_SIZE-2:0], 1'b1};
      end else begin
        o_hi = shifted[BITS_SIZE-1:0];
        o_lo = {i_lo[BITS_SIZE-2:0], 1'b0};
      end
    end else begin
      o_hi = sum[BITS_SIZE:1];
      o_lo = {sum[0], i_lo[BITS_SIZE-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multicycle multiply/divide unit owning the HI/LO registers.
//   i_clk, i_reset       : clock, asynchronous active-high reset
//   i_step               : advance enable; all state frozen when low
//   i_start, i_op        : mult/div/move-to request and its op code
//   i_rs_data, i_rt_data : operands A and B
//   i_read_hilo          : MFHI/MFLO present in EX
//   o_hi, o_lo           : architectural HI/LO
//   o_busy               : iteration in progress
//   o_stall              : hold the front of the pipeline (combinational)
//   o_done               : one-cycle pulse after a mult/div writes HI/LO
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int BITS_SIZE = 32,
  parameter int BITS_CNT  = 6
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_step,
  input  logic                 i_start,
  input  logic [2:0]           i_op,
  input  logic [BITS_SIZE-1:0] i_rs_data,
  input  logic [BITS_SIZE-1:0] i_rt_data,
  input  logic                 i_read_hilo,
  output logic [BITS_SIZE-1:0] o_hi,
  output logic [BITS_SIZE-1:0] o_lo,
  output logic                 o_busy,
  output logic                 o_stall,
  output logic                 o_done
);

  localparam logic [BITS_CNT-1:0] LAST_ITER = BITS_CNT'(BITS_SIZE - 1);

  state_e                 state_q, state_d;
  op_e                    op_q, op_d;
  logic [BITS_CNT-1:0]    cnt_q, cnt_d;
  logic [BITS_SIZE-1:0]   acc_q, acc_d;       // product high half / remainder
  logic [BITS_SIZE-1:0]   work_q, work_d;     // multiplier / dividend -> quotient
  logic [BITS_SIZE-1:0]   bmag_q, bmag_d;     // |B|
  logic [BITS_SIZE-1:0]   aorig_q, aorig_d;   // A as presented, for divide-by-zero
  logic                   sign_a_q, sign_a_d;
  logic                   sign_b_q, sign_b_d;
  logic [BITS_SIZE-1:0]   hi_q, hi_d;
  logic [BITS_SIZE-1:0]   lo_q, lo_d;
  logic                   done_q, done_d;

  logic [BITS_SIZE-1:0]   core_hi, core_lo;
  logic                   is_div;
  logic [2*BITS_SIZE-1:0] prod_raw, prod_fix;
  logic [BITS_SIZE-1:0]   quo_fix, rem_fix;

  assign is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);

  muldiv_iter_core #(
    .BITS_SIZE (BITS_SIZE)
  ) u_core (
    .is_div (is_div),
    .i_hi   (acc_q),
    .i_lo   (work_q),
    .i_b    (bmag_q),
    .o_hi   (core_hi),
    .o_lo   (core_lo)
  );

  // Sign correction of the finished magnitudes. Unsigned ops never set the
  // sign flags, so they pass through untouched.
  always_comb begin
    prod_raw = {acc_q, work_q};
    prod_fix = (sign_a_q ^ sign_b_q) ? -prod_raw : prod_raw;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -work_q : work_q;
    rem_fix  = sign_a_q ? -acc_q : acc_q;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    work_d   = work_q;
    bmag_d   = bmag_q;
    aorig_d  = aorig_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = done_q;

    if (i_step) begin
      done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            if (op_is_iter(i_op)) begin
              op_d     = op_e'(i_op);
              cnt_d    = '0;
              state_d  = ST_RUN;
              sign_a_d = op_is_signed(i_op) & i_rs_data[BITS_SIZE-1];
              sign_b_d = op_is_signed(i_op) & i_rt_data[BITS_SIZE-1];
              acc_d    = '0;
              work_d   = sign_a_d ? -i_rs_data : i_rs_data;
              bmag_d   = sign_b_d ? -i_rt_data : i_rt_data;
              aorig_d  = i_rs_data;
            end else if (i_op == OP_MTHI) begin
              hi_d = i_rs_data;
            end else if (i_op == OP_MTLO) begin
              lo_d = i_rs_data;
            end
          end
        end
        ST_RUN: begin
          acc_d  = core_hi;
          work_d = core_lo;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state_d = ST_FIX;
          end
        end
        ST_FIX: begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (!is_div) begin
            hi_d = prod_fix[2*BITS_SIZE-1:BITS_SIZE];
            lo_d = prod_fix[BITS_SIZE-1:0];
          end else if (bmag_q == '0) begin
            // Divide by zero: quotient saturates, A is handed back in HI.
            hi_d = aorig_q;
            lo_d = DIVZERO_LO[BITS_SIZE-1:0];
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MULT;
      cnt_q    <= '0;
      acc_q    <= '0;
      work_q   <= '0;
      bmag_q   <= '0;
      aorig_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      work_q   <= work_d;
      bmag_q   <= bmag_d;
      aorig_q  <= aorig_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign o_hi    = hi_q;
  assign o_lo    = lo_q;
  assign o_done  = done_q;
  assign o_busy  = (state_q != ST_IDLE);
  // Only a dependent instruction (another mult/div/move-to or an MFHI/MFLO)
  // has to wait; unrelated instructions flow past the busy unit.
  assign o_stall = o_busy & (i_start | i_read_hilo);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

  localparam logic [2:0] C_MULT  = 3'd0;
  localparam logic [2:0] C_MULTU = 3'd1;
  localparam logic [2:0] C_DIV   = 3'd2;
  localparam logic [2:0] C_DIVU  = 3'd3;
  localparam logic [2:0] C_MTHI  = 3'd4;
  localparam logic [2:0] C_MTLO  = 3'd5;

  logic        clk;
  logic        i_reset;
  logic        i_step;
  logic        i_start;
  logic [2:0]  i_op;
  logic [31:0] i_rs_data;
  logic [31:0] i_rt_data;
  logic        i_read_hilo;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic        o_busy;
  logic        o_stall;
  logic        o_done;

  int checks = 0;
  int errors = 0;

  ex_muldiv_unit dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_step      (i_step),
    .i_start     (i_start),
    .i_op        (i_op),
    .i_rs_data   (i_rs_data),
    .i_rt_data   (i_rt_data),
    .i_read_hilo (i_read_hilo),
    .o_hi        (o_hi),
    .o_lo        (o_lo),
    .o_busy      (o_busy),
    .o_stall     (o_stall),
    .o_done      (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one mult/div, then step until the unit is idle again (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int edges, output int busy_cycles, output int early_done);
    i_start = 1'b1; i_op = op; i_rs_data = a; i_rt_data = b;
    tick();
    i_start = 1'b0;
    edges = 1; busy_cycles = 0; early_done = 0;
    while (o_busy === 1'b1 && edges < 200) begin
      busy_cycles++;
      if (o_done === 1'b1) early_done++;
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_step = 1'b1; i_start = 1'b0; i_op = 3'd0;
    i_rs_data = '0; i_rt_data = '0; i_read_hilo = 1'b0;
    repeat (2) tick();
    checks++; if (o_hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", o_hi); end
    checks++; if (o_lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", o_lo); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", o_stall); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", o_done); end
    #3 i_reset = 1'b0;
    tick();
    $display("reset: hi=%h lo=%h busy=%b", o_hi, o_lo, o_busy);
  endtask

  task automatic test_multu();
    int e, bc, ed;
    run_op(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e, bc, ed);
    $display("MULTU ffffffff*ffffffff: edges=%0d busy=%0d hi=%h lo=%h", e, bc, o_hi, o_lo);
    checks++; if (e != 34) begin errors++; $display("FAIL multu_latency: got %0d expected 34", e); end
    checks++; if (bc != 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d expected 33", bc); end
    checks++; if (ed != 0) begin errors++; $display("FAIL multu_early_done: got %0d expected 0", ed); end
    checks++; if (o_hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h expected fffffffe", o_hi); end
    checks++; if (o_lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h expected 00000001", o_lo); end
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL multu_done: got %b expected 1", o_done); end
    tick();
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b expected 0", o_done); end
  endtask

  task automatic test_signed();
    int e, bc, ed;
    run_op(C_MULT, 32'hFFFF_FFFD, 32'h0000_0007, e, bc, ed);
    $display("MULT -3*7: edges=%0d hi=%h lo=%h", e, o_hi, o_lo);
    checks++; if (o_hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", o_hi); end
    checks++; if (o_lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo: got %h expected ffffffeb", o_lo); end
    run_op(C_DIV, 32'hFFFF_FFF9, 32'h0000_0002, e, bc, ed);
    $display("DIV -7/2: edges=%0d hi=%h lo=%h", e, o_hi, o_lo);
    checks++; if (e != 34) begin errors++; $display("FAIL div_latency: got %0d expected 34", e); end
    checks++; if (o_lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_quotient: got %h expected fffffffd", o_lo); end
    checks++; if (o_hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_remainder: got %h expected ffffffff", o_hi); end
  endtask

  task automatic test_div_corners();
    int e, bc, ed;
    run_op(C_DIVU, 32'd100, 32'd7, e, bc, ed);
    $display("DIVU 100/7: hi=%h lo=%h", o_hi, o_lo);
    checks++; if (o_lo !== 32'd14) begin errors++; $display("FAIL divu_quotient: got %h expected 0000000e", o_lo); end
    checks++; if (o_hi !== 32'd2) begin errors++; $display("FAIL divu_remainder: got %h expected 00000002", o_hi); end
    run_op(C_DIVU, 32'd100, 32'd0, e, bc, ed);
    $display("DIVU 100/0: edges=%0d hi=%h lo=%h", e, o_hi, o_lo);
    checks++; if (e != 34) begin errors++; $display("FAIL divzero_latency: got %0d expected 34", e); end
    checks++; if (o_lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divzero_lo: got %h expected ffffffff", o_lo); end
    checks++; if (o_hi !== 32'd100) begin errors++; $display("FAIL divzero_hi: got %h expected 00000064", o_hi); end
    run_op(C_DIV, 32'hFFFF_FFFB, 32'd0, e, bc, ed);
    $display("DIV -5/0: hi=%h lo=%h", o_hi, o_lo);
    checks++; if (o_lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sdivzero_lo: got %h expected ffffffff", o_lo); end
    checks++; if (o_hi !== 32'hFFFF_FFFB) begin errors++; $display("FAIL sdivzero_hi: got %h expected fffffffb", o_hi); end
    run_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, e, bc, ed);
    $display("DIV 80000000/ffffffff: hi=%h lo=%h", o_hi, o_lo);
    checks++; if (o_lo !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo: got %h expected 80000000", o_lo); end
    checks++; if (o_hi !== 32'h0) begin errors++; $display("FAIL divovf_hi: got %h expected 00000000", o_hi); end
  endtask

  task automatic test_stall_read();
    int n, n_stall, n_bad;
    i_read_hilo = 1'b1; #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL stall_idle: got %b expected 0", o_stall); end
    i_read_hilo = 1'b0;
    i_start = 1'b1; i_op = C_MULTU; i_rs_data = 32'h0001_0000; i_rt_data = 32'h0003_0000;
    tick();
    i_start = 1'b0;
    repeat (4) tick();
    i_read_hilo = 1'b1; #1;
    n = 0; n_stall = 0; n_bad = 0;
    while (o_busy === 1'b1 && n < 100) begin
      if (o_stall === 1'b1) n_stall++; else n_bad++;
      tick();
      n++;
    end
    $display("MFHI stall: stalled=%0d unstalled_busy=%0d hi=%h stall_now=%b", n_stall, n_bad, o_hi, o_stall);
    checks++; if (n_stall != 29) begin errors++; $display("FAIL stall_cycles: got %0d expected 29", n_stall); end
    checks++; if (n_bad != 0) begin errors++; $display("FAIL stall_gaps: got %0d expected 0", n_bad); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL stall_release: got %b expected 0", o_stall); end
    checks++; if (o_hi !== 32'h3) begin errors++; $display("FAIL stall_hi_valid: got %h expected 00000003", o_hi); end
    i_read_hilo = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n, bc;
    i_start = 1'b1; i_op = C_MULTU; i_rs_data = 32'd6; i_rt_data = 32'd7;
    tick();
    i_start = 1'b0;
    repeat (3) tick();
    i_start = 1'b1; i_op = C_MULT; i_rs_data = 32'hFFFF_FFFE; i_rt_data = 32'd3; #1;
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL b2b_stall: got %b expected 1", o_stall); end
    n = 0;
    while (o_busy === 1'b1 && n < 100) begin tick(); n++; end
    checks++; if (o_lo !== 32'd42) begin errors++; $display("FAIL b2b_first_lo: got %h expected 0000002a", o_lo); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL b2b_idle_stall: got %b expected 0", o_stall); end
    tick();
    i_start = 1'b0;
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b expected 1", o_busy); end
    bc = 0;
    while (o_busy === 1'b1 && bc < 100) begin bc++; tick(); end
    $display("back-to-back: second busy=%0d hi=%h lo=%h", bc, o_hi, o_lo);
    checks++; if (bc != 33) begin errors++; $display("FAIL b2b_busy_cycles: got %0d expected 33", bc); end
    checks++; if (o_hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_hi: got %h expected ffffffff", o_hi); end
    checks++; if (o_lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL b2b_lo: got %h expected fffffffa", o_lo); end
  endtask

  task automatic test_step_freeze();
    int clocks, bad;
    i_start = 1'b1; i_op = C_MULTU; i_rs_data = 32'h1234_5678; i_rt_data = 32'h10;
    tick();
    i_start = 1'b0; clocks = 1;
    repeat (10) begin tick(); clocks++; end
    i_step = 1'b0; bad = 0;
    repeat (10) begin
      tick(); clocks++;
      if (o_busy !== 1'b1 || o_done !== 1'b0 || o_hi !== 32'hFFFF_FFFF || o_lo !== 32'hFFFF_FFFA) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL freeze_hold: got %0d changed cycles expected 0", bad); end
    i_step = 1'b1;
    while (o_busy === 1'b1 && clocks < 200) begin tick(); clocks++; end
    $display("step freeze: clocks=%0d hi=%h lo=%h", clocks, o_hi, o_lo);
    checks++; if (clocks != 44) begin errors++; $display("FAIL freeze_latency: got %0d expected 44", clocks); end
    checks++; if (o_hi !== 32'h1) begin errors++; $display("FAIL freeze_hi: got %h expected 00000001", o_hi); end
    checks++; if (o_lo !== 32'h2345_6780) begin errors++; $display("FAIL freeze_lo: got %h expected 23456780", o_lo); end
    i_step = 1'b0;
    tick();
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL freeze_done_held: got %b expected 1", o_done); end
    i_step = 1'b1;
    tick();
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL freeze_done_clear: got %b expected 0", o_done); end
  endtask

  task automatic test_reset_mid();
    i_start = 1'b1; i_op = C_MULTU; i_rs_data = 32'hFFFF_FFFF; i_rt_data = 32'd2;
    tick();
    i_start = 1'b0;
    repeat (5) tick();
    i_read_hilo = 1'b1;
    #2 i_reset = 1'b1;
    #1;
    $display("async reset mid-run: hi=%h lo=%h busy=%b stall=%b", o_hi, o_lo, o_busy, o_stall);
    checks++; if (o_hi !== 32'h0) begin errors++; $display("FAIL rstmid_hi: got %h expected 00000000", o_hi); end
    checks++; if (o_lo !== 32'h0) begin errors++; $display("FAIL rstmid_lo: got %h expected 00000000", o_lo); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", o_busy); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b expected 0", o_stall); end
    i_read_hilo = 1'b0;
    #2 i_reset = 1'b0;
    i_start = 1'b1; i_op = C_MTLO; i_rs_data = 32'h1234;
    tick();
    $display("MTLO 1234: hi=%h lo=%h done=%b busy=%b", o_hi, o_lo, o_done, o_busy);
    checks++; if (o_lo !== 32'h1234) begin errors++; $display("FAIL mtlo_lo: got %h expected 00001234", o_lo); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL mtlo_done: got %b expected 0", o_done); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy: got %b expected 0", o_busy); end
    i_op = C_MTHI; i_rs_data = 32'hABCD;
    tick();
    checks++; if (o_hi !== 32'hABCD) begin errors++; $display("FAIL mthi_hi: got %h expected 0000abcd", o_hi); end
    i_op = 3'd7; i_rs_data = 32'h5555;
    tick();
    i_start = 1'b0;
    $display("unlisted op: hi=%h lo=%h busy=%b", o_hi, o_lo, o_busy);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL badop_busy: got %b expected 0", o_busy); end
    checks++; if (o_hi !== 32'hABCD || o_lo !== 32'h1234) begin
      errors++; $display("FAIL badop_hilo: got %h/%h expected 0000abcd/00001234", o_hi, o_lo);
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_signed();
    test_div_corners();
    test_stall_read();
    test_back_to_back();
    test_step_freeze();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Multicycle multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the operand registers and the decoded mult/div/move-to control that ID/EX produces.
- Owns the architectural HI/LO registers and iterates one radix-2 step per enabled cycle.
- Raises a stall toward the hazard unit while a dependent instruction must wait.

Parameters:
- BITS_SIZE, 32, operand/HI/LO width.
- BITS_CNT, 6, iteration counter width; must hold BITS_SIZE.

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  asynchronous, active-high reset
- i_step  input  1  pipeline advance enable (debug stepping); all state frozen when 0
- i_start  input  1  EX holds MULT/MULTU/DIV/DIVU/MTHI/MTLO this cycle
- i_op  input  3  operation code (see package)
- i_rs_data  input  BITS_SIZE  operand A (rs value after forwarding)
- i_rt_data  input  BITS_SIZE  operand B (rt value after forwarding)
- i_read_hilo  input  1  EX holds MFHI/MFLO this cycle
- o_hi  output  BITS_SIZE  HI register
- o_lo  output  BITS_SIZE  LO register
- o_busy  output  1  iteration in progress
- o_stall  output  1  freeze IF/ID/IDEX, bubble EX/MEM
- o_done  output  1  one-cycle pulse on HI/LO update by a mult/div

Behaviour:
- Reset (async, active-high): state IDLE; HI=LO=0; counter=0; o_busy=o_stall=o_done=0.
- Reset mid-operation aborts the operation; HI/LO return to 0.
- States:
  - IDLE: waiting for work.
  - RUN: one iteration per stepped edge.
  - FIX: sign correction and HI/LO write.
- Accept rule: in IDLE, a stepped edge with i_start and op MULT/MULTU/DIV/DIVU latches operands and op, clears the counter, and moves to RUN.
- MTHI/MTLO in IDLE: write i_rs_data to HI or LO on that stepped edge; no state change; o_done stays 0.
- RUN: each stepped edge performs one iteration and increments the counter. After the BITS_SIZE-th iteration, go to FIX.
  - Multiply: shift-add on magnitudes; 64-bit {acc, multiplier} shifted right.
  - Divide: restoring shift-subtract on magnitudes.
- FIX: the next stepped edge applies the sign fix, writes HI/LO, and returns to IDLE. o_done is high for the cycle following that edge.
- Latency: results are visible on o_hi/o_lo exactly BITS_SIZE+2 stepped edges after the accept edge (34 for the default).
- o_busy = (state != IDLE).
- o_stall = o_busy & (i_start | i_read_hilo). It is combinational and is never asserted in IDLE.
- A stalled start is re-presented by the held pipeline and is accepted on the first IDLE stepped edge.
- Signed handling (MULT/DIV):
  - Operate on absolute values.
  - Product negated if signs differ.
  - Quotient sign = signA xor signB; remainder sign = signA.
- Unsigned ops (MULTU/DIVU) bypass the sign logic.
- Results: MULT/MULTU give HI = product[63:32], LO = product[31:0]. DIV/DIVU give LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = operand A unmodified. It takes the full latency; no exception.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): LO = 0x80000000, HI = 0.
- When i_step=0: counter, state, HI/LO and o_done are all held. o_stall remains combinational.
- i_start with an unlisted op code is ignored.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings: MULT=3'd0, MULTU=3'd1, DIV=3'd2, DIVU=3'd3, MTHI=3'd4, MTLO=3'd5;
  - state encoding IDLE/RUN/FIX;
  - DIVZERO_LO constant.
- One sub-module, muldiv_iter_core: a combinational single-step shift-add/shift-subtract datapath, selected by an is_div input. The top level owns the FSM, counter, sign logic and HI/LO.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 34 stepped edges HI=0xFFFFFFFE, LO=0x00000001; o_done pulses once; o_busy high for 33 cycles.
- MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=100, B=0 -> LO=0xFFFFFFFF, HI=100. DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MFHI asserted 5 cycles after MULTU accept -> o_stall=1 until state returns to IDLE, then 0 the same cycle HI is valid. Second MULT while busy -> stalled, accepted on first IDLE edge, no lost result.
- i_step held 0 for 10 cycles mid-RUN -> counter/HI/LO frozen; total latency becomes 34 stepped edges (44 clocks).
- Reset asserted asynchronously mid-RUN -> all outputs 0 immediately. MTLO 0x1234 after release -> LO=0x1234 next edge, o_done stays 0.
